// File: rtl/udp_cmd_pkg.sv
// Shared definitions for the UDP command FIFO path and its arbiters.
package udp_cmd_pkg;

   localparam int CMD_DATA_W   = 32;
   localparam int CMD_WORD_W   = CMD_DATA_W + 1;
   localparam int CMD_LAST_BIT = CMD_DATA_W;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/udp_rr_pick.sv
// Rotating-priority picker: selects the first asserted request at or after ptr_i,
// scanning upward with wrap-around. Purely combinational.
module udp_rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             any_o
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   rot;

   // rot[k] is the request of source (ptr_i + k) mod N
   assign req_dbl = {req_i, req_i};
   assign rot     = req_dbl[ptr_i +: N];

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return PTR_W'(s);
   endfunction

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            any_o = 1'b1;
            idx_o = wrap_add(ptr_i, k);
         end
      end
      gnt_o[idx_o] = any_o;
   end

endmodule

// File: rtl/udp_cmd_arbiter.sv
// Packet-atomic round-robin arbiter feeding the shared UDP command FIFO.
// A granted source owns the FIFO until its (possibly forced) last beat is written.
module udp_cmd_arbiter
   import udp_cmd_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = CMD_DATA_W,
   parameter int MAX_BEATS = 64,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      fifo_wr_en,
   output logic [DATA_W:0]           fifo_wr_data,
   input  logic                      fifo_full,
   input  logic                      fifo_almost_full,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic                      err_overlen,
   input  logic                      err_clr,
   output logic [CNT_W-1:0]          pkt_cnt
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W = $clog2(MAX_BEATS + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
   localparam logic [PTR_W-1:0]  LAST_SRC  = PTR_W'(NUM_REQ - 1);

   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [PTR_W-1:0]    gidx_q;
   logic [PTR_W-1:0]    rr_ptr_q;
   logic [PTR_W-1:0]    rr_ptr_d;
   logic [BEAT_W-1:0]   beat_cnt_q;
   logic                wr_en_q;
   logic [DATA_W:0]     wr_data_q;
   logic                err_q;
   logic [CNT_W-1:0]    pkt_cnt_q;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_any;
   logic                space_ok;
   logic                accept;
   logic                last_eff;
   logic [DATA_W-1:0]   data_sel;

   udp_rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Almost-full leaves room for the one beat still in the write register.
   assign space_ok  = !fifo_almost_full && !fifo_full;
   assign req_ready = (state_q == BUSY && space_ok) ? grant_q : '0;
   assign accept    = (state_q == BUSY) && req_valid[gidx_q] && space_ok;
   assign data_sel  = req_data[gidx_q*DATA_W +: DATA_W];
   assign last_eff  = req_last[gidx_q] || (beat_cnt_q == LAST_BEAT);
   assign rr_ptr_d  = (gidx_q == LAST_SRC) ? '0 : gidx_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         err_q      <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (err_clr) err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_gnt;
                  gidx_q  <= pick_idx;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (accept) begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= {last_eff, data_sel};
                  if (last_eff) begin
                     state_q    <= IDLE;
                     grant_q    <= '0;
                     rr_ptr_q   <= rr_ptr_d;
                     beat_cnt_q <= '0;
                     pkt_cnt_q  <= pkt_cnt_q + 1'b1;
                     // placed after the clear so a same-cycle set wins
                     if (!req_last[gidx_q]) err_q <= 1'b1;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = wr_data_q;
   assign grant        = grant_q;
   assign busy         = (state_q == BUSY);
   assign err_overlen  = err_q;
   assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_udp_cmd_arbiter.sv
// Bench for udp_cmd_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules and a FIFO occupancy model.
module tb_udp_cmd_arbiter;

   localparam int NR     = 4;
   localparam int DW     = 32;
   localparam int MAXB   = 8;
   localparam int CW     = 16;
   localparam int DEPTH  = 64;
   localparam int AF_THR = 62;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_last = '0;
   logic [NR-1:0]     req_ready;
   logic              fifo_wr_en;
   logic [DW:0]       fifo_wr_data;
   logic              fifo_full = 1'b0;
   logic              fifo_almost_full = 1'b0;
   logic [NR-1:0]     grant;
   logic              busy;
   logic              err_overlen;
   logic              err_clr = 1'b0;
   logic [CW-1:0]     pkt_cnt;

   always #5 clk = ~clk;

   udp_cmd_arbiter #(
      .NUM_REQ   (NR),
      .DATA_W    (DW),
      .MAX_BEATS (MAXB),
      .CNT_W     (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_last         (req_last),
      .req_ready        (req_ready),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .grant            (grant),
      .busy             (busy),
      .err_overlen      (err_overlen),
      .err_clr          (err_clr),
      .pkt_cnt          (pkt_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus state: per-source beat queues ({last, data}) and knobs.
   logic [DW:0] src_q [NR][$];
   bit          hold [NR];
   int          vprob    = 100;
   int          rd_prob  = 100;
   int          clr_prob = 0;
   bit          af_force = 1'b0;
   int          occ = 0;
   int          cyc = 0;
   logic [DW:0] wr_log[$];
   int          wr_cyc[$];

   // Reference model: owner index (-1 = nobody), round-robin start, beats in grant.
   int          m_owner = -1;
   int          m_ptr   = 0;
   int          m_beats = 0;
   int          m_pkt   = 0;
   bit          m_err   = 1'b0;
   bit          m_wr_en = 1'b0;
   logic [DW:0] m_wr_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_beats = 0; m_pkt = 0;
      m_err = 1'b0; m_wr_en = 1'b0; m_wr_data = '0;
   endtask

   task automatic model_step();
      int o;
      bit lst, set_err, nxt_wr;
      if (rst) begin
         model_reset();
         return;
      end
      set_err = 1'b0;
      nxt_wr  = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < NR; k++) begin
            o = (m_ptr + k) % NR;
            if (req_valid[o]) begin
               m_owner = o;
               break;
            end
         end
      end else if (req_valid[m_owner] && !fifo_almost_full && !fifo_full) begin
         o = m_owner;
         m_beats = m_beats + 1;
         lst = req_last[o] || (m_beats == MAXB);
         nxt_wr = 1'b1;
         m_wr_data = {lst, req_data[o*DW +: DW]};
         void'(src_q[o].pop_front());
         if (lst) begin
            m_owner = -1;
            m_ptr   = (o + 1) % NR;
            m_beats = 0;
            m_pkt   = (m_pkt + 1) % (1 << CW);
            if (!req_last[o]) set_err = 1'b1;
         end
      end
      m_err   = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
      m_wr_en = nxt_wr;
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model.
   task automatic cycle();
      logic [NR-1:0] exp_rdy;
      @(negedge clk);
      cyc++;
      if (rst) occ = 0;
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0 && !hold[i] && $urandom_range(99) < vprob) begin
            req_valid[i] = 1'b1;
            {req_last[i], req_data[i*DW +: DW]} = src_q[i][0];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'($urandom_range(1));
            req_data[i*DW +: DW] = $urandom;
         end
      end
      fifo_full        = (occ >= DEPTH);
      fifo_almost_full = af_force || (occ >= AF_THR);
      err_clr          = ($urandom_range(99) < clr_prob);
      #1;
      exp_rdy = '0;
      if (m_owner >= 0 && !fifo_almost_full && !fifo_full) exp_rdy[m_owner] = 1'b1;
      chk("grant", grant, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
      chk("busy", busy, m_owner >= 0);
      chk("req_ready", req_ready, exp_rdy);
      chk("wr_en", fifo_wr_en, m_wr_en);
      if (m_wr_en) chk("wr_data", fifo_wr_data, m_wr_data);
      chk("err_overlen", err_overlen, m_err);
      chk("pkt_cnt", pkt_cnt, m_pkt);
      if (fifo_wr_en) begin
         wr_log.push_back(fifo_wr_data);
         wr_cyc.push_back(cyc);
         occ++;
         chk("fifo_no_overflow", occ <= DEPTH, 1);
      end
      if (occ > 0 && $urandom_range(99) < rd_prob) occ--;
      model_step();
   endtask

   function automatic logic [31:0] mkdata(input int s, input int t, input int b);
      return {8'(s), 8'(t), 8'(b), 8'hC3};
   endfunction

   task automatic load(input int s, input int len, input int t);
      for (int b = 0; b < len; b++) src_q[s].push_back({1'(b == len - 1), mkdata(s, t, b)});
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_until_idle(input int budget);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         cycle();
         n++;
         done = all_empty() && m_owner < 0 && !m_wr_en;
      end
      chk("idle_timeout", done, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) begin
         src_q[i].delete();
         hold[i] = 1'b0;
      end
      model_reset();
      occ = 0;
      repeat (2) cycle();
      rst = 1'b0;
      wr_log.delete();
      wr_cyc.delete();
   endtask

   task automatic refill();
      int len;
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() == 0 && $urandom_range(3) == 0) begin
            len = $urandom_range(1, 12);
            load(i, len, $urandom_range(255));
         end
      end
   endtask

   initial begin
      int a, n0;
      int exp_src [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

      // Reset values
      repeat (3) cycle();
      chk("rst_grant", grant, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      rst = 1'b0;

      // Single 3-beat packet from source 0
      wr_log.delete(); wr_cyc.delete();
      a = cyc;
      load(0, 3, 1);
      cycle(); cycle();
      chk("t1_grant", grant, 4'b0001);
      run_until_idle(40);
      chk("t1_nwrites", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         for (int b = 0; b < 3; b++) chk("t1_word", wr_log[b], {1'(b == 2), mkdata(0, 1, b)});
         chk("t1_first_wr_cycle", wr_cyc[0] - a, 3);
         chk("t1_last_wr_cycle", wr_cyc[2] - a, 5);
      end
      chk("t1_pkt_cnt", pkt_cnt, 1);
      chk("t1_busy", busy, 0);

      // All sources contend with 2-beat packets; source 0 has a second packet
      do_reset();
      for (int s = 0; s < NR; s++) load(s, 2, 2);
      load(0, 2, 3);
      run_until_idle(80);
      chk("t2_nwrites", wr_log.size(), 10);
      if (wr_log.size() == 10) begin
         for (int k = 0; k < 10; k++) chk("t2_src_order", wr_log[k][31:24], exp_src[k]);
         chk("t2_back_to_back", wr_cyc[1] - wr_cyc[0], 1);
         chk("t2_bubble", wr_cyc[2] - wr_cyc[1], 2);
      end
      chk("t2_pkt_cnt", pkt_cnt, 5);

      // Over-length packet truncated at MAX_BEATS
      do_reset();
      load(1, 10, 4);
      run_until_idle(60);
      chk("t3_nwrites", wr_log.size(), 10);
      if (wr_log.size() == 10) begin
         chk("t3_beat7_last", wr_log[6][DW], 0);
         chk("t3_beat8_forced_last", wr_log[7][DW], 1);
         chk("t3_beat10_last", wr_log[9][DW], 1);
         chk("t3_rearb_bubble", wr_cyc[8] - wr_cyc[7], 2);
      end
      chk("t3_err_set", err_overlen, 1);
      chk("t3_pkt_cnt", pkt_cnt, 2);
      clr_prob = 100; cycle(); clr_prob = 0; cycle();
      chk("t3_err_cleared", err_overlen, 0);

      // Almost-full throttling mid-packet
      do_reset();
      load(0, 8, 5);
      n0 = 0;
      while (src_q[0].size() != 6 && n0 < 20) begin cycle(); n0++; end
      chk("t4_reach_beat2", src_q[0].size(), 6);
      af_force = 1'b1;
      n0 = wr_log.size();
      cycle();
      chk("t4_ready_drop", req_ready, 0);
      repeat (4) cycle();
      chk("t4_inflight_writes", wr_log.size() - n0, 1);
      af_force = 1'b0;
      cycle();
      chk("t4_ready_back", req_ready, 4'b0001);
      cycle();
      chk("t4_write_resume", fifo_wr_en, 1);
      run_until_idle(40);
      chk("t4_nwrites", wr_log.size(), 8);

      // Granted source stalls while another waits
      do_reset();
      load(2, 3, 6);
      cycle();
      hold[2] = 1'b1;
      load(3, 2, 7);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("t5_grant_held", grant, 4'b0100);
         chk("t5_no_write", fifo_wr_en, 0);
         chk("t5_ready3_low", req_ready[3], 0);
      end
      hold[2] = 1'b0;
      run_until_idle(40);
      chk("t5_nwrites", wr_log.size(), 5);
      if (wr_log.size() == 5) chk("t5_src3_after", wr_log[3][31:24], 3);

      // Reset mid-packet, then source 0 wins regardless of earlier pointer
      do_reset();
      load(1, 2, 8);
      run_until_idle(30);
      load(2, 6, 9);
      repeat (4) cycle();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ready", req_ready, 0);
      chk("t6_rst_wr_en", fifo_wr_en, 0);
      chk("t6_rst_wr_data", fifo_wr_data, 0);
      chk("t6_rst_pkt_cnt", pkt_cnt, 0);
      do_reset();
      for (int s = 0; s < NR; s++) load(s, 2, 10);
      cycle(); cycle();
      chk("t6_src0_first", grant, 4'b0001);
      run_until_idle(60);

      // Randomized traffic: light load, heavy backpressure, mixed
      vprob = 70; clr_prob = 5;
      rd_prob = 90; repeat (1500) begin refill(); cycle(); end
      rd_prob = 5;  repeat (600)  begin refill(); cycle(); end
      rd_prob = 60; repeat (500)  begin refill(); cycle(); end
      rd_prob = 100; clr_prob = 0;
      run_until_idle(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
